// File: rtl/ret_addr_stack.sv
// Return-address stack for the fetch stage.
// A call pushes call_pc+2 and a return pops it. Storage is a circular buffer,
// so an overflow overwrites the oldest entry and the newest DEPTH return
// addresses are kept. All outputs come from registered state.
module ret_addr_stack #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] call_pc,
    output logic [DATA_W-1:0] top_addr,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] ret_addr;
    logic              empty_w, full_w;

    assign ret_addr = call_pc + DATA_W'(2);
    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == (PTR_W+1)'(DEPTH));

    // Next-state decode for pointer, count, error flags and the storage write.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_ptr  = top_q + PTR_W'(1);
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        if (push && pop && !empty_w) begin
            // Call and return together: overwrite the top entry in place.
            wr_en  = 1'b1;
            wr_ptr = top_q;
        end else if (push) begin
            wr_en = 1'b1;
            top_d = top_q + PTR_W'(1);
            if (full_w) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + (PTR_W+1)'(1);
            end
            // push+pop on an empty stack behaves as a push but flags the pop.
            if (pop) begin
                unf_d = 1'b1;
            end
        end else if (pop) begin
            if (empty_w) begin
                unf_d = 1'b1;
            end else begin
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - (PTR_W+1)'(1);
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr] <= ret_addr;
        end
    end

    assign top_addr  = empty_w ? '0 : mem_q[top_q];
    assign empty     = empty_w;
    assign full      = full_w;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Testbench for ret_addr_stack: directed steps followed by random traffic,
// each compared against a queue-based model of the stack.
module tb_ret_addr_stack;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] call_pc = '0;
    logic [DW-1:0] top_addr;
    logic          empty, full, overflow, underflow;
    logic [PW:0]   count;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of return addresses, oldest at the front.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 0;
    bit            m_unf = 0;

    ret_addr_stack #(.DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .call_pc(call_pc),
        .top_addr(top_addr), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit ps, input bit pp,
                                input logic [DW-1:0] pc, input bit clr);
        bit o = 0, u = 0;
        logic [DW-1:0] ret;
        if (r) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            ret = pc + 16'd2;
            if (ps && pp && mq.size() != 0) begin
                mq[mq.size()-1] = ret;
            end else if (ps) begin
                if (mq.size() == DEPTH) begin
                    void'(mq.pop_front());
                    o = 1;
                end
                mq.push_back(ret);
                if (pp) u = 1;
            end else if (pp) begin
                if (mq.size() == 0) u = 1;
                else void'(mq.pop_back());
            end
            if (clr) begin
                m_ovf = 0;
                m_unf = 0;
            end
            m_ovf = m_ovf | o;
            m_unf = m_unf | u;
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] et;
        et = (mq.size() == 0) ? '0 : mq[mq.size()-1];
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".top"}, 32'(top_addr), 32'(et));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // One clock: drive inputs, clock edge, update model, sample #1 later.
    task automatic step(input string tag, input bit r, input bit ps, input bit pp,
                        input logic [DW-1:0] pc, input bit clr);
        rst = r; push = ps; pop = pp; call_pc = pc; clr_err = clr;
        @(posedge clk);
        model_update(r, ps, pp, pc, clr);
        #1;
        rst = 0; push = 0; pop = 0; clr_err = 0;
        check_all(tag);
    endtask

    initial begin
        // Reset, then idle
        step("rst", 1, 0, 0, 16'h0, 0);
        step("idle", 0, 0, 0, 16'h0, 0);
        chk("idle.top_const", 32'(top_addr), 32'h0);

        // Basic push/pop order
        step("push100", 0, 1, 0, 16'h0100, 0);
        step("push200", 0, 1, 0, 16'h0200, 0);
        chk("lifo.top0", 32'(top_addr), 32'h0202);
        step("pop1", 0, 0, 1, 16'h0, 0);
        chk("lifo.top1", 32'(top_addr), 32'h0102);
        step("pop2", 0, 0, 1, 16'h0, 0);
        chk("lifo.top2", 32'(top_addr), 32'h0000);
        chk("lifo.empty", 32'(empty), 32'h1);

        // Address wrap at the top of the address space
        step("pushFFFE", 0, 1, 0, 16'hFFFE, 0);
        chk("wrap.top0", 32'(top_addr), 32'h0000);
        step("pushFFFF", 0, 1, 0, 16'hFFFF, 0);
        chk("wrap.top1", 32'(top_addr), 32'h0001);
        chk("wrap.count", 32'(count), 32'd2);
        step("drain_a", 0, 0, 1, 16'h0, 0);
        step("drain_b", 0, 0, 1, 16'h0, 0);

        // Overflow: ten pushes into an eight-entry stack
        for (int i = 0; i < 10; i++) begin
            step("ovf_push", 0, 1, 0, 16'(16'h1000 + 4*i), 0);
            if (i == 7) chk("ovf.full8", 32'(full), 32'h1);
            if (i == 7) chk("ovf.noovf8", 32'(overflow), 32'h0);
            if (i == 8) chk("ovf.set9", 32'(overflow), 32'h1);
        end
        for (int j = 0; j < 8; j++) begin
            chk("ovf.popval", 32'(top_addr), 32'(16'h1000 + 4*(9-j) + 2));
            step("ovf_pop", 0, 0, 1, 16'h0, 0);
        end
        step("unf_pop", 0, 0, 1, 16'h0, 0);
        chk("unf.set", 32'(underflow), 32'h1);
        chk("unf.count", 32'(count), 32'h0);
        step("clr0", 0, 0, 0, 16'h0, 1);

        // Simultaneous push and pop
        step("p300a", 0, 1, 0, 16'h0100, 0);
        step("p300b", 0, 1, 0, 16'h0200, 0);
        step("p300c", 0, 1, 0, 16'h0300, 0);
        step("pp500", 0, 1, 1, 16'h0500, 0);
        chk("pp.top", 32'(top_addr), 32'h0502);
        chk("pp.count", 32'(count), 32'd3);
        chk("pp.noflag", 32'({overflow, underflow}), 32'h0);
        for (int j = 0; j < 3; j++) step("pp_drain", 0, 0, 1, 16'h0, 0);
        step("pp600", 0, 1, 1, 16'h0600, 0);
        chk("ppe.count", 32'(count), 32'd1);
        chk("ppe.top", 32'(top_addr), 32'h0602);
        chk("ppe.unf", 32'(underflow), 32'h1);

        // Error flag clearing
        for (int i = 0; i < 8; i++) step("fill", 0, 1, 0, 16'(16'h2000 + 2*i), 0);
        chk("flags.both", 32'({overflow, underflow}), 32'h3);
        step("clr", 0, 0, 0, 16'h0, 1);
        chk("clr.both", 32'({overflow, underflow}), 32'h0);
        for (int j = 0; j < 8; j++) step("drain_c", 0, 0, 1, 16'h0, 0);
        step("clr_pop", 0, 0, 1, 16'h0, 1);
        chk("clrset.unf", 32'(underflow), 32'h1);

        // Reset wins over push
        for (int i = 0; i < 5; i++) step("five", 0, 1, 0, 16'(16'h3000 + i), 0);
        step("rst_push", 1, 1, 0, 16'h4000, 0);
        chk("rstp.count", 32'(count), 32'h0);
        chk("rstp.empty", 32'(empty), 32'h1);
        chk("rstp.top", 32'(top_addr), 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            bit ps, pp, cl, rs;
            r  = $urandom_range(0, 99);
            ps = (r < 55);
            pp = ($urandom_range(0, 99) < 45);
            cl = ($urandom_range(0, 99) < 5);
            rs = ($urandom_range(0, 199) == 0);
            step("rand", rs, ps, pp, 16'($urandom), cl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
Hardware return-address stack for the fetch stage. On a call it pushes the return address, which is the call PC plus 2 computed inside the block. On a return it pops that address back to fetch. The block completes the PC path in the opposite direction to the sequential incrementer: addresses go in at call time and come out at return time. Storage is a circular buffer, so overflow overwrites the oldest entry and the newest DEPTH return addresses are kept.

Parameters:
DATA_W, 16, address width in bits
DEPTH, 8, number of entries; must be a power of 2
PTR_W, 3, log2(DEPTH)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
push  input  1  call retiring this cycle
pop  input  1  return retiring this cycle
call_pc  input  DATA_W  PC of the call instruction; sampled when push=1
top_addr  output  DATA_W  current top-of-stack return address; 0 when empty
empty  output  1  count==0
full  output  1  count==DEPTH
count  output  PTR_W+1  number of valid entries, 0..DEPTH
overflow  output  1  sticky; a push occurred while full
underflow  output  1  sticky; a pop occurred while empty
clr_err  input  1  clears overflow and underflow

Behaviour:
- Reset (rst=1 at a clock edge):
  - count=0, top pointer=0, overflow=0, underflow=0.
  - Outputs: empty=1, full=0, top_addr=0.
  - Storage contents are don't-care.
  - rst overrides push, pop and clr_err in the same cycle.
- Return-address arithmetic:
  - ret = call_pc + 2, modulo 2^DATA_W.
  - 16'hFFFE yields 16'h0000 and 16'hFFFF yields 16'h0001, with no carry out.
  - Odd call_pc values are not rejected.
- top_addr is a combinational read of the entry at the top pointer, gated to 0 when empty. A pushed value is visible on the cycle after the push edge. A pop exposes the next-older entry on the cycle after the pop edge.
- Per-edge operation, evaluated on registered state:
  - push only, not full: write ret at top+1 (mod DEPTH), top<=top+1, count+1.
  - push only, full: write ret at top+1 (mod DEPTH), overwriting the oldest entry. top<=top+1, count stays DEPTH, overflow<=1.
  - pop only, not empty: top<=top-1 (mod DEPTH), count-1. Storage is unchanged.
  - pop only, empty: no state change except underflow<=1.
  - push and pop, not empty: replace the top entry with ret in place. Pointer and count are unchanged and no flag is set. This also holds when full.
  - push and pop, empty: act as push only (count becomes 1), underflow<=1.
  - neither: hold.
- Error flags:
  - Both flags are sticky until clr_err=1 or rst=1.
  - If clr_err and a new error condition occur on the same edge, the flag ends at 1 (set wins).
- Pointer wrap: pointers wrap modulo DEPTH. After k>DEPTH consecutive pushes, successive pops return the last DEPTH addresses newest-first. The stack then reports empty.
- empty, full and count are derived from the registered count only. There is no combinational path from push or pop to any output.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, top_addr=16'h0000, overflow=0, underflow=0.
- Push call_pc=16'h0100, then 16'h0200, then pop twice → top_addr reads 16'h0202, then 16'h0102, then 16'h0000; empty=1 at the end; no flags set.
- Push call_pc=16'hFFFE, then 16'hFFFF → top_addr sequence 16'h0000, 16'h0001; count=2.
- Push 10 times with call_pc=16'h1000+4*i, i=0..9 → full=1 from the 8th push, overflow=1 after the 9th push. Eight pops then yield 16'h1026, 16'h1022, … 16'h100A. A 9th pop sets underflow=1, and count stays 0.
- With count=3 and top=16'h0302, assert push (call_pc=16'h0500) and pop together → top_addr=16'h0502, count=3. With empty, assert push+pop (call_pc=16'h0600) → count=1, top_addr=16'h0602, underflow=1.
- Set both flags, then pulse clr_err alone → both flags 0. Pulse clr_err with a pop while empty → underflow=1. Assert rst together with push while count=5 → count=0, empty=1, top_addr=0.
